// File: rtl/rf_transceiver_pkg.sv
// Shared constants and state encoding for the RF transceiver bridge blocks.
package rf_transceiver_pkg;

    localparam int DATA_WIDTH                 = 8;
    localparam int BUFFER_512_DEPTH           = 512;
    localparam int BUFFER_512_ADDR_WIDTH      = 9;
    // A wireless burst starts once more than this many bytes are buffered.
    localparam int START_WIRELESS_TRANS_VALUE = 57;
    // Idle cycles after the last MCU byte (about three byte times) that end a packet.
    localparam int END_COUNTER_RX_PACKET      = 6511;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COLLECT   = 2'd1,
        DRAIN     = 2'd2,
        WAIT_DONE = 2'd3
    } wtrans_state_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO: RAM array with binary read/write pointers and an occupancy count.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Full and empty are judged on the pre-edge count, so a push into a full
    // FIFO is dropped even when a pop frees a slot in the same cycle.
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage array, written on accepted pushes only.
    // NOTE: the array has no reset; pointers and count alone define which
    // entries are valid, and an unreset array maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer advance with wrap at DEPTH-1, and occupancy tracking.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wireless_tx_packet_buffer.sv
// Byte buffer between the MCU UART receiver and the node UART transmitter.
// Collects MCU bytes, then drains them to the node once a threshold is hit
// or the MCU line has gone quiet, and reports wireless-transmit/busy status.
module wireless_tx_packet_buffer #(
    parameter int DATA_WIDTH                 = rf_transceiver_pkg::DATA_WIDTH,
    parameter int BUFFER_DEPTH               = rf_transceiver_pkg::BUFFER_512_DEPTH,
    parameter int ADDR_WIDTH                 = rf_transceiver_pkg::BUFFER_512_ADDR_WIDTH,
    parameter int START_WIRELESS_TRANS_VALUE = rf_transceiver_pkg::START_WIRELESS_TRANS_VALUE,
    parameter int END_COUNTER_RX_PACKET      = rf_transceiver_pkg::END_COUNTER_RX_PACKET
) (
    input  logic                  internal_clk,
    input  logic                  rst_n,
    input  logic                  mcu_rx_flag,
    input  logic [DATA_WIDTH-1:0] mcu_rx_data,
    output logic                  mcu_rx_use,
    input  logic                  node_tx_flag,
    input  logic                  node_tx_complete,
    output logic                  node_tx_use,
    output logic [DATA_WIDTH-1:0] node_tx_data,
    output logic                  wtrans_active,
    output logic                  aux_busy_n,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   fill_count
);

    import rf_transceiver_pkg::*;

    localparam int                    GAP_WIDTH   = $clog2(END_COUNTER_RX_PACKET + 1);
    localparam logic [GAP_WIDTH-1:0]  GAP_END     = GAP_WIDTH'(END_COUNTER_RX_PACKET);
    localparam logic [ADDR_WIDTH:0]   START_LEVEL = (ADDR_WIDTH + 1)'(START_WIRELESS_TRANS_VALUE);

    wtrans_state_t         state;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;

    // Bytes are accepted in every state; pops happen only while draining and
    // the node TX FIFO has room, one per cycle.
    assign push       = mcu_rx_flag && !full;
    assign pop        = (state == DRAIN) && !node_tx_flag && !empty;
    assign fill_count = count;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUFFER_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (internal_clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (mcu_rx_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // MCU acknowledge, sticky overflow and node write strobe with its data.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            mcu_rx_use   <= 1'b0;
            overflow     <= 1'b0;
            node_tx_use  <= 1'b0;
            node_tx_data <= '0;
        end else begin
            // Every MCU byte is acknowledged, even one dropped on a full buffer.
            mcu_rx_use  <= mcu_rx_flag;
            if (mcu_rx_flag && full) begin
                overflow <= 1'b1;
            end
            node_tx_use <= pop;
            if (pop) begin
                node_tx_data <= head_data;
            end
        end
    end

    // Line-idle timer: restarts on each stored byte, counts quiet cycles in
    // COLLECT and saturates; outside COLLECT it is held at zero so a return to
    // COLLECT from WAIT_DONE starts a fresh idle interval.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (push) begin
            gap_cnt <= '0;
        end else if (state == COLLECT) begin
            if (!mcu_rx_flag && (gap_cnt != GAP_END)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end else begin
            gap_cnt <= '0;
        end
    end

    // Transmit sequencer with status outputs registered from the current state.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wtrans_active <= 1'b0;
            aux_busy_n    <= 1'b1;
        end else begin
            wtrans_active <= (state == DRAIN) || (state == WAIT_DONE);
            aux_busy_n    <= empty && (state == IDLE);
            case (state)
                IDLE: begin
                    if (mcu_rx_flag) begin
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if ((count > START_LEVEL) || ((gap_cnt == GAP_END) && !empty)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (node_tx_complete) begin
                        state <= empty ? IDLE : COLLECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wireless_tx_packet_buffer.sv
// Self-checking bench for wireless_tx_packet_buffer: a hand-computed vector
// table, directed multi-cycle sequences and randomized traffic, all compared
// every cycle against a queue-based reference model.
module tb_wireless_tx_packet_buffer;

    localparam int DEPTH     = 512;
    localparam int START_VAL = 57;
    localparam int GAP_END   = 6511;

    logic       internal_clk = 1'b0;
    logic       rst_n;
    logic       mcu_rx_flag;
    logic [7:0] mcu_rx_data;
    logic       mcu_rx_use;
    logic       node_tx_flag;
    logic       node_tx_complete;
    logic       node_tx_use;
    logic [7:0] node_tx_data;
    logic       wtrans_active;
    logic       aux_busy_n;
    logic       overflow;
    logic [9:0] fill_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] stream[$];
    logic [7:0] exp_q[$];

    wireless_tx_packet_buffer dut (
        .internal_clk     (internal_clk),
        .rst_n            (rst_n),
        .mcu_rx_flag      (mcu_rx_flag),
        .mcu_rx_data      (mcu_rx_data),
        .mcu_rx_use       (mcu_rx_use),
        .node_tx_flag     (node_tx_flag),
        .node_tx_complete (node_tx_complete),
        .node_tx_use      (node_tx_use),
        .node_tx_data     (node_tx_data),
        .wtrans_active    (wtrans_active),
        .aux_busy_n       (aux_busy_n),
        .overflow         (overflow),
        .fill_count       (fill_count)
    );

    always #5 internal_clk = ~internal_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {PH_IDLE, PH_COLLECT, PH_DRAIN, PH_WAIT} phase_t;

    logic [7:0] m_q[$];
    phase_t     m_phase;
    int         m_gap;
    logic       m_ovf, m_mcu_use, m_tx_use, m_wa, m_busy_n;
    logic [7:0] m_tx_data;

    task automatic model_reset();
        m_q.delete();
        m_phase   = PH_IDLE;
        m_gap     = 0;
        m_ovf     = 1'b0;
        m_mcu_use = 1'b0;
        m_tx_use  = 1'b0;
        m_tx_data = 8'h00;
        m_wa      = 1'b0;
        m_busy_n  = 1'b1;
    endtask

    task automatic model_step();
        int     n;
        logic   full_now;
        logic   do_push;
        logic   do_pop;
        phase_t next_phase;
        n        = m_q.size();
        full_now = (n == DEPTH);
        do_push  = mcu_rx_flag && !full_now;
        do_pop   = (m_phase == PH_DRAIN) && !node_tx_flag && (n > 0);
        m_mcu_use = mcu_rx_flag;
        if (mcu_rx_flag && full_now) m_ovf = 1'b1;
        m_tx_use = do_pop;
        if (do_pop) m_tx_data = m_q[0];
        m_wa     = (m_phase == PH_DRAIN) || (m_phase == PH_WAIT);
        m_busy_n = (n == 0) && (m_phase == PH_IDLE);
        next_phase = m_phase;
        case (m_phase)
            PH_IDLE:    if (mcu_rx_flag) next_phase = PH_COLLECT;
            PH_COLLECT: if (n > START_VAL || (m_gap == GAP_END && n > 0)) next_phase = PH_DRAIN;
            PH_DRAIN:   if (n == 0) next_phase = PH_WAIT;
            PH_WAIT:    if (node_tx_complete) next_phase = (n == 0) ? PH_IDLE : PH_COLLECT;
            default:    next_phase = PH_IDLE;
        endcase
        if (do_push) m_gap = 0;
        else if (m_phase == PH_COLLECT) begin
            if (!mcu_rx_flag && m_gap < GAP_END) m_gap++;
        end else m_gap = 0;
        m_phase = next_phase;
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(mcu_rx_data);
    endtask

    // Model advances on the same edges as the DUT.
    always @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge internal_clk) begin
        if (rst_n === 1'b1) begin
            check("cycle_model",
                  {9'd0, mcu_rx_use, node_tx_use, node_tx_data, wtrans_active, aux_busy_n, overflow, fill_count},
                  {9'd0, m_mcu_use, m_tx_use, m_tx_data, m_wa, m_busy_n, m_ovf, 10'(m_q.size())});
        end
    end

    // Capture of bytes written to the node (sampled before the edge updates).
    always @(posedge internal_clk) begin
        if (rst_n === 1'b1 && node_tx_use === 1'b1) stream.push_back(node_tx_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        mcu_rx_flag      = 1'b0;
        mcu_rx_data      = 8'h00;
        node_tx_flag     = 1'b0;
        node_tx_complete = 1'b0;
        @(negedge internal_clk);
        rst_n = 1'b0;
        repeat (2) @(negedge internal_clk);
        rst_n = 1'b1;
        stream.delete();
        exp_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] d);
        mcu_rx_flag = 1'b1;
        mcu_rx_data = d;
        @(negedge internal_clk);
        mcu_rx_flag = 1'b0;
    endtask

    task automatic wait_wa(input int budget, input string name);
        int n = 0;
        while (wtrans_active !== 1'b1 && n < budget) begin
            @(negedge internal_clk);
            n++;
        end
        check(name, wtrans_active, 1);
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n = 0;
        while (fill_count !== 10'd0 && n < budget) begin
            @(negedge internal_clk);
            n++;
        end
        check(name, fill_count, 0);
    endtask

    task automatic pulse_complete();
        node_tx_complete = 1'b1;
        @(negedge internal_clk);
        node_tx_complete = 1'b0;
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, stream.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < stream.size(); i++) begin
            check(name, stream[i], exp_q[i]);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       flag;
        logic [7:0] data;
        logic       use_exp;
        logic [9:0] cnt_exp;
        logic       wa_exp;
        logic       busy_n_exp;
    } vec_t;

    vec_t vecs[6];
    int   flag_pct[4]  = '{60, 30, 90, 5};
    int   stall_pct[4] = '{20, 50, 95, 0};

    initial begin
        int held;
        int bad;

        // Status outputs follow the state/count one cycle late.
        vecs[0] = '{1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'h11, 1'b1, 10'd1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 8'h22, 1'b1, 10'd2, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 10'd2, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h33, 1'b1, 10'd3, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 10'd3, 1'b0, 1'b0};

        rst_n            = 1'b0;
        mcu_rx_flag      = 1'b0;
        mcu_rx_data      = 8'h00;
        node_tx_flag     = 1'b0;
        node_tx_complete = 1'b0;
        repeat (2) @(negedge internal_clk);
        check("reset_fill", fill_count, 0);
        check("reset_busy_n", aux_busy_n, 1);
        check("reset_wa", wtrans_active, 0);
        check("reset_ovf", overflow, 0);
        check("reset_tx_use", node_tx_use, 0);
        check("reset_mcu_use", mcu_rx_use, 0);
        check("reset_tx_data", node_tx_data, 0);

        // Table vectors.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            mcu_rx_flag = vecs[i].flag;
            mcu_rx_data = vecs[i].data;
            @(negedge internal_clk);
            check("vec_mcu_use", mcu_rx_use, vecs[i].use_exp);
            check("vec_fill", fill_count, vecs[i].cnt_exp);
            check("vec_wa", wtrans_active, vecs[i].wa_exp);
            check("vec_busy_n", aux_busy_n, vecs[i].busy_n_exp);
        end
        mcu_rx_flag = 1'b0;

        // 58 back-to-back bytes trigger the threshold drain.
        do_reset();
        for (int i = 0; i < 58; i++) begin
            push_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        @(negedge internal_clk);
        check("thr_not_yet", wtrans_active, 0);
        @(negedge internal_clk);
        check("thr_wa", wtrans_active, 1);
        check("thr_first_use", node_tx_use, 1);
        check("thr_first_data", node_tx_data, 8'h00);
        wait_empty(200, "thr_empty");
        repeat (3) @(negedge internal_clk);
        check("thr_wait_wa", wtrans_active, 1);
        check("thr_wait_busy", aux_busy_n, 0);
        check_stream("thr_stream");
        pulse_complete();
        @(negedge internal_clk);
        check("thr_idle_wa", wtrans_active, 0);
        check("thr_idle_busy", aux_busy_n, 1);

        // 5 bytes then silence: idle count reaches its end 6511 cycles after
        // the last byte, DRAIN is entered one edge later and the status and
        // first write appear one edge after that.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_byte(8'hA1 + 8'(i));
            exp_q.push_back(8'hA1 + 8'(i));
        end
        repeat (6512) @(negedge internal_clk);
        check("gap_early_wa", wtrans_active, 0);
        check("gap_early_use", node_tx_use, 0);
        @(negedge internal_clk);
        check("gap_wa", wtrans_active, 1);
        check("gap_first_use", node_tx_use, 1);
        check("gap_first_data", node_tx_data, 8'hA1);
        wait_empty(50, "gap_empty");
        repeat (3) @(negedge internal_clk);
        check_stream("gap_stream");

        // Back-pressure for 100 cycles in the middle of a drain.
        do_reset();
        for (int i = 0; i < 58; i++) begin
            push_byte(8'(i) ^ 8'h5A);
            exp_q.push_back(8'(i) ^ 8'h5A);
        end
        repeat (4) @(negedge internal_clk);
        node_tx_flag = 1'b1;
        @(negedge internal_clk);
        held = int'(fill_count);
        check("stall_level", fill_count, 55);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge internal_clk);
            if (node_tx_use !== 1'b0 || fill_count !== 10'(held)) bad++;
        end
        check("stall_held", bad, 0);
        node_tx_flag = 1'b0;
        wait_empty(200, "stall_empty");
        repeat (3) @(negedge internal_clk);
        check_stream("stall_stream");
        pulse_complete();

        // 513 bytes into a stalled buffer: the last one is dropped.
        do_reset();
        node_tx_flag = 1'b1;
        for (int i = 0; i < 512; i++) begin
            push_byte(8'(i * 5 + 7));
            exp_q.push_back(8'(i * 5 + 7));
        end
        check("ovf_full_level", fill_count, 512);
        check("ovf_not_yet", overflow, 0);
        push_byte(8'hEE);
        check("ovf_set", overflow, 1);
        check("ovf_level", fill_count, 512);
        check("ovf_ack", mcu_rx_use, 1);
        node_tx_flag = 1'b0;
        wait_empty(1000, "ovf_empty");
        repeat (3) @(negedge internal_clk);
        check_stream("ovf_stream");
        check("ovf_sticky", overflow, 1);
        pulse_complete();

        // Push and pop together at count 1 across the 511 -> 0 pointer wrap.
        do_reset();
        node_tx_flag = 1'b1;
        for (int i = 0; i < 511; i++) push_byte(8'(i));
        node_tx_flag = 1'b0;
        wait_empty(1000, "wrap_prep_empty");
        repeat (3) @(negedge internal_clk);
        pulse_complete();
        repeat (2) @(negedge internal_clk);
        stream.delete();
        node_tx_flag = 1'b1;
        push_byte(8'hB0);
        exp_q.push_back(8'hB0);
        wait_wa(7000, "wrap_drain");
        check("wrap_level", fill_count, 1);
        node_tx_flag = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            mcu_rx_flag = 1'b1;
            mcu_rx_data = 8'hB0 + 8'(k);
            exp_q.push_back(8'hB0 + 8'(k));
            @(negedge internal_clk);
            check("wrap_fill", fill_count, 1);
            check("wrap_use", node_tx_use, 1);
        end
        mcu_rx_flag = 1'b0;
        wait_empty(20, "wrap_empty");
        repeat (3) @(negedge internal_clk);
        check_stream("wrap_stream");

        // Asynchronous reset while draining with 20 bytes buffered.
        do_reset();
        for (int i = 0; i < 25; i++) push_byte(8'h60 + 8'(i));
        begin
            int n = 0;
            while (fill_count !== 10'd20 && n < 8000) begin
                @(negedge internal_clk);
                n++;
            end
        end
        check("arst_pre_fill", fill_count, 20);
        check("arst_pre_use", node_tx_use, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_fill", fill_count, 0);
        check("arst_use", node_tx_use, 0);
        check("arst_busy_n", aux_busy_n, 1);
        check("arst_wa", wtrans_active, 0);
        check("arst_mcu_use", mcu_rx_use, 0);
        @(negedge internal_clk);
        rst_n = 1'b1;

        // Randomized traffic against the model, then a long silence.
        do_reset();
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 1500; c++) begin
                mcu_rx_flag      = ($urandom_range(99) < flag_pct[seg]);
                mcu_rx_data      = 8'($urandom);
                node_tx_flag     = ($urandom_range(99) < stall_pct[seg]);
                node_tx_complete = ($urandom_range(99) < 10);
                @(negedge internal_clk);
            end
        end
        mcu_rx_flag = 1'b0;
        for (int c = 0; c < 6700; c++) begin
            node_tx_flag     = ($urandom_range(99) < 20);
            node_tx_complete = ($urandom_range(99) < 10);
            @(negedge internal_clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
